// File: rtl/axis_bram_frame_writer_pkg.sv
// Shared definitions for the triggered BRAM frame writer: FSM encoding and status width.
package axis_bram_frame_writer_pkg;

    localparam int STS_STATE_W = 2;

    typedef enum logic [STS_STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } fw_state_t;

endpackage

// File: rtl/axis_bram_frame_writer.sv
// Triggered frame capture: writes cfg_data+1 AXI-Stream words into BRAM port B at
// addresses 0..cfg_data, then raises a config handshake to signal a complete frame.
module axis_bram_frame_writer
    import axis_bram_frame_writer_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_DATA_WIDTH  = 32,
    parameter int BRAM_ADDR_WIDTH  = 10
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [BRAM_ADDR_WIDTH-1:0]    cfg_data,
    input  logic                          cfg_arm,
    input  logic                          trg_flag,
    output logic [BRAM_ADDR_WIDTH-1:0]    sts_data,
    output logic [STS_STATE_W-1:0]        sts_state,
    output logic                          s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          m_axis_config_tready,
    output logic                          m_axis_config_tvalid,
    output logic                          bram_portb_clk,
    output logic                          bram_portb_rst,
    output logic [BRAM_DATA_WIDTH/8-1:0]  bram_portb_we,
    output logic [BRAM_ADDR_WIDTH-1:0]    bram_portb_addr,
    output logic [BRAM_DATA_WIDTH-1:0]    bram_portb_wrdata
);

    localparam int BYTE_LANES = BRAM_DATA_WIDTH / 8;
    localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE = BRAM_ADDR_WIDTH'(1);

    generate
        if (AXIS_TDATA_WIDTH != BRAM_DATA_WIDTH) begin : g_width_check
            $error("AXIS_TDATA_WIDTH must equal BRAM_DATA_WIDTH");
        end
        if ((BRAM_DATA_WIDTH % 8) != 0) begin : g_byte_check
            $error("BRAM_DATA_WIDTH must be a multiple of 8");
        end
    endgenerate

    fw_state_t                  state_q, state_d;
    logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BRAM_ADDR_WIDTH-1:0] cfg_lat_q, cfg_lat_d;
    logic                       arm_d_q;
    logic                       arm_rise;
    logic                       wr_en;

    assign arm_rise = cfg_arm & ~arm_d_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            cfg_lat_q <= '0;
            arm_d_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cfg_lat_q <= cfg_lat_d;
            arm_d_q   <= cfg_arm;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cfg_lat_d = cfg_lat_q;
        case (state_q)
            ST_IDLE: begin
                addr_d = '0;
                if (arm_rise) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // The trigger beat itself is word 0; the frame length is frozen here.
                if (s_axis_tvalid && trg_flag) begin
                    cfg_lat_d = cfg_data;
                    if (cfg_data == '0) begin
                        addr_d  = '0;
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = ADDR_ONE;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (s_axis_tvalid) begin
                    if (addr_q == cfg_lat_q) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
            end
            ST_DONE: begin
                if (m_axis_config_tready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign wr_en = s_axis_tvalid &
                   ((state_q == ST_WRITE) | ((state_q == ST_ARMED) & trg_flag));

    assign s_axis_tready        = 1'b1;
    assign m_axis_config_tvalid = (state_q == ST_DONE);
    assign sts_data             = addr_q;
    assign sts_state            = state_q;

    assign bram_portb_clk    = aclk;
    assign bram_portb_rst    = areset;
    assign bram_portb_we     = {BYTE_LANES{wr_en}};
    assign bram_portb_addr   = addr_q;
    assign bram_portb_wrdata = s_axis_tdata;

endmodule

// File: tb/tb_axis_bram_frame_writer.sv
// Randomized bench for axis_bram_frame_writer against a frame-level reference model.
module tb_axis_bram_frame_writer;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NB = DW / 8;

    logic          aclk = 1'b0;
    logic          areset = 1'b0;
    logic [AW-1:0] cfg_data = '0;
    logic          cfg_arm = 1'b0;
    logic          trg_flag = 1'b0;
    logic [AW-1:0] sts_data;
    logic [1:0]    sts_state;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          m_axis_config_tready = 1'b0;
    logic          m_axis_config_tvalid;
    logic          bram_portb_clk;
    logic          bram_portb_rst;
    logic [NB-1:0] bram_portb_we;
    logic [AW-1:0] bram_portb_addr;
    logic [DW-1:0] bram_portb_wrdata;

    axis_bram_frame_writer #(
        .AXIS_TDATA_WIDTH(DW),
        .BRAM_DATA_WIDTH (DW),
        .BRAM_ADDR_WIDTH (AW)
    ) dut (
        .aclk                (aclk),
        .areset              (areset),
        .cfg_data            (cfg_data),
        .cfg_arm             (cfg_arm),
        .trg_flag            (trg_flag),
        .sts_data            (sts_data),
        .sts_state           (sts_state),
        .s_axis_tready       (s_axis_tready),
        .s_axis_tdata        (s_axis_tdata),
        .s_axis_tvalid       (s_axis_tvalid),
        .m_axis_config_tready(m_axis_config_tready),
        .m_axis_config_tvalid(m_axis_config_tvalid),
        .bram_portb_clk      (bram_portb_clk),
        .bram_portb_rst      (bram_portb_rst),
        .bram_portb_we       (bram_portb_we),
        .bram_portb_addr     (bram_portb_addr),
        .bram_portb_wrdata   (bram_portb_wrdata)
    );

    always #5 aclk = ~aclk;

    // Behavioural BRAM on port B
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int unsigned   wr_total = 0;
    always @(posedge aclk) begin
        if (|bram_portb_we) begin
            mem[bram_portb_addr] <= bram_portb_wrdata;
            wr_total <= wr_total + 1;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic sample();
        @(negedge aclk);
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] st, input logic [AW-1:0] ad,
                            input logic cv, input logic we1);
        check({tag, ".state"}, sts_state, st);
        check({tag, ".addr"}, sts_data, ad);
        check({tag, ".baddr"}, bram_portb_addr, ad);
        check({tag, ".cfg_tvalid"}, m_axis_config_tvalid, cv);
        check({tag, ".we"}, bram_portb_we, {NB{we1}});
        check({tag, ".tready"}, s_axis_tready, 1'b1);
    endtask

    task automatic do_arm();
        cfg_arm = 1'b0; s_axis_tvalid = 1'b0; trg_flag = 1'b0; m_axis_config_tready = 1'b0;
        sample();
        check("idle.state", sts_state, 2'd0);
        check("idle.cfg_tvalid", m_axis_config_tvalid, 1'b0);
        tick();
        cfg_arm = 1'b1;
        sample();
        chk_outs("arm", 2'd0, '0, 1'b0, 1'b0);
        tick();
        cfg_arm = 1'b0;
    endtask

    // mode: 0 continuous, 1 alternating valid, 2 random gaps
    // chg: new cfg_data applied after the trigger (<0: none); abort_at: beat count at which to reset (<0: none)
    task automatic run_frame(input int cfg, input int mode, input int chg, input int abort_at);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] d;
        logic          tv;
        int            w = 0;
        int            cyc = 0;
        int unsigned   wr0;

        cfg_data = AW'(cfg);
        do_arm();

        for (int i = 0; i < 3; i++) begin
            trg_flag = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = $urandom;
            sample();
            chk_outs("qual_trg", 2'd1, '0, 1'b0, 1'b0);
            tick();
        end
        trg_flag = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = $urandom;
        sample();
        chk_outs("qual_vld", 2'd1, '0, 1'b0, 1'b0);
        tick();

        wr0 = wr_total;
        while (w < cfg + 1) begin
            if (cyc > 5000) begin
                check("frame_timeout", 64'(w), 64'(cfg + 1));
                break;
            end
            if (w == abort_at) begin
                cfg_arm = 1'b0; s_axis_tvalid = 1'b1; trg_flag = 1'b1; s_axis_tdata = $urandom;
                #2;
                areset = 1'b1;
                #1;
                chk_outs("rst_async", 2'd0, '0, 1'b0, 1'b0);
                tick();
                areset = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    s_axis_tvalid = 1'b1; trg_flag = 1'b1; s_axis_tdata = $urandom;
                    sample();
                    chk_outs("post_rst", 2'd0, '0, 1'b0, 1'b0);
                    tick();
                end
                check("partial_count", 64'(wr_total - wr0), 64'(abort_at));
                for (int i = 0; i < abort_at; i++) check("partial_mem", mem[i], exp_q[i]);
                s_axis_tvalid = 1'b0; trg_flag = 1'b0;
                return;
            end
            if (w == 0) tv = 1'b1;
            else if (mode == 0) tv = 1'b1;
            else if (mode == 1) tv = (cyc % 2 == 0);
            else tv = ($urandom_range(0, 3) != 0);
            d = $urandom;
            s_axis_tvalid = tv;
            s_axis_tdata  = d;
            trg_flag      = (w == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            cfg_arm       = 1'($urandom_range(0, 1));
            if (chg >= 0 && w == 3) cfg_data = AW'(chg);
            sample();
            chk_outs("frame", (w == 0) ? 2'd1 : 2'd2, AW'(w), 1'b0, tv);
            if (tv) check("wrdata", bram_portb_wrdata, d);
            tick();
            if (tv) begin
                exp_q.push_back(d);
                w++;
            end
            cyc++;
        end

        for (int i = 0; i < 5; i++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = $urandom;
            trg_flag = 1'($urandom_range(0, 1)); cfg_arm = 1'(i % 2);
            m_axis_config_tready = 1'b0;
            sample();
            chk_outs("done_hold", 2'd3, AW'(cfg), 1'b1, 1'b0);
            tick();
        end
        m_axis_config_tready = 1'b1; cfg_arm = 1'b0; s_axis_tvalid = 1'b0;
        sample();
        chk_outs("done_ack", 2'd3, AW'(cfg), 1'b1, 1'b0);
        tick();
        m_axis_config_tready = 1'b0;
        sample();
        check("after_ack.state", sts_state, 2'd0);
        check("after_ack.cfg_tvalid", m_axis_config_tvalid, 1'b0);

        check("wr_count", 64'(wr_total - wr0), 64'(cfg + 1));
        for (int i = 0; i <= cfg && i < exp_q.size(); i++) check("mem", mem[i], exp_q[i]);
        tick();
    endtask

    initial begin
        #2;
        areset = 1'b1;
        #1;
        chk_outs("reset", 2'd0, '0, 1'b0, 1'b0);
        check("reset.bram_rst", bram_portb_rst, 1'b1);
        @(posedge aclk);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        check("reset.bram_rst_rel", bram_portb_rst, 1'b0);

        run_frame(7, 0, -1, -1);
        run_frame(3, 1, -1, -1);
        run_frame(0, 2, -1, -1);
        run_frame(7, 2, 2, -1);
        run_frame(1023, 2, -1, -1);
        for (int k = 0; k < 4; k++) run_frame(int'($urandom_range(0, 40)), 2, int'($urandom_range(0, 5)), -1);
        run_frame(9, 0, -1, 4);
        run_frame(5, 2, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
